// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV64I control unit.
// The trap states exist only when CTRL_TRAP_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_SHIFT     = 4'd5,
        S_ADDR      = 4'd6,
        S_MEM_RD    = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WR    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12
`ifdef CTRL_TRAP_EN
        ,
        S_TRAP_SAVE = 4'd13,
        S_TRAP_JUMP = 4'd14
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_AND, C_SLT, C_ADDI, C_SLTI, C_SLLI, C_SRLI,
        C_SRAI, C_LD, C_SD, C_BEQ, C_BNE, C_JALR, C_LUI, C_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_SRL  = 6'b000000;
    localparam logic [5:0] F6_SRA  = 6'b010000;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;

    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_MDR   = 3'd1;
    localparam logic [2:0] WB_IMM   = 3'd2;
    localparam logic [2:0] WB_LT    = 3'd3;
    localparam logic [2:0] WB_SHIFT = 3'd4;
    localparam logic [2:0] WB_PC    = 3'd5;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_TRAP   = 2'd2;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_SB = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;

    localparam logic [1:0] B_REG  = 2'd0;
    localparam logic [1:0] B_FOUR = 2'd1;
    localparam logic [1:0] B_IMM  = 2'd2;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    function automatic state_t dispatch(input iclass_t c);
        state_t s;
        case (c)
            C_ADD, C_SUB, C_AND, C_SLT: s = S_EXEC_R;
            C_ADDI, C_SLTI:             s = S_EXEC_I;
            C_SLLI, C_SRLI, C_SRAI:     s = S_SHIFT;
            C_LD, C_SD:                 s = S_ADDR;
            C_BEQ, C_BNE:               s = S_BRANCH;
            C_JALR:                     s = S_JALR;
            C_LUI:                      s = S_LUI;
`ifdef CTRL_TRAP_EN
            default:                    s = S_TRAP_SAVE;
`else
            default:                    s = S_FETCH;
`endif
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the IR word onto an
// instruction class plus an illegal flag for the control FSM.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign f6     = instr[31:26];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (f3 == F3_ADD && f7 == F7_BASE)      iclass = C_ADD;
                else if (f3 == F3_ADD && f7 == F7_ALT)  iclass = C_SUB;
                else if (f3 == F3_AND && f7 == F7_BASE) iclass = C_AND;
                else if (f3 == F3_SLT && f7 == F7_BASE) iclass = C_SLT;
            end
            OP_IMM: begin
                case (f3)
                    F3_ADD:  iclass = C_ADDI;
                    F3_SLT:  iclass = C_SLTI;
                    F3_SLL:  iclass = C_SLLI;
                    F3_SR: begin
                        if (f6 == F6_SRL)      iclass = C_SRLI;
                        else if (f6 == F6_SRA) iclass = C_SRAI;
                    end
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_LOAD:   if (f3 == F3_D) iclass = C_LD;
            OP_STORE:  if (f3 == F3_D) iclass = C_SD;
            OP_BRANCH: begin
                if (f3 == F3_BEQ)      iclass = C_BEQ;
                else if (f3 == F3_BNE) iclass = C_BNE;
            end
            OP_JALR:   if (f3 == 3'b000) iclass = C_JALR;
            OP_LUI:    iclass = C_LUI;
            default:   iclass = C_ILLEGAL;
        endcase
        illegal = (iclass == C_ILLEGAL);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV64I control FSM with a MEM_LAT-cycle memory wait counter.
// Define CTRL_TRAP_EN to route illegal instructions through the trap states.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter  int MEM_LAT = 1,
    localparam int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic        imem_read,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        ir_load,
    output logic        a_load,
    output logic        b_load,
    output logic        aluout_load,
    output logic        mdr_load,
    output logic        reg_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic [1:0]  shift_sel,
    output logic [2:0]  wb_sel,
    output logic        epc_load,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    iclass_t          iclass;
    logic             dec_illegal;
    logic             last;

    ctrl_decode u_decode (
        .instr   (instr),
        .iclass  (iclass),
        .illegal (dec_illegal)
    );

    assign last = (cnt == LAST_CNT);

    // Counter is cleared on every transition, so it is 0 on entry to each wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            cnt   <= '0;
        end else begin
            cnt <= '0;
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (last) state <= S_DECODE; else cnt <= cnt + 1'b1;
                S_DECODE: state <= dispatch(iclass);
                S_ADDR:   state <= (iclass == C_SD) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: if (last) state <= S_MEM_WB; else cnt <= cnt + 1'b1;
                S_MEM_WR: if (last) state <= S_FETCH;  else cnt <= cnt + 1'b1;
`ifdef CTRL_TRAP_EN
                S_TRAP_SAVE: state <= S_TRAP_JUMP;
`endif
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_read   = 1'b0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        ir_load     = 1'b0;
        a_load      = 1'b0;
        b_load      = 1'b0;
        aluout_load = 1'b0;
        mdr_load    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_ALU;
        alu_a_sel   = 1'b0;
        alu_b_sel   = B_REG;
        alu_op      = ALU_PASS;
        imm_type    = IMM_I;
        shift_sel   = SH_SLL;
        wb_sel      = WB_ALU;
        epc_load    = 1'b0;
        illegal     = 1'b0;
        state_dbg   = state;
        case (state)
            S_FETCH: begin
                imem_read = 1'b1;
                if (last) begin
                    ir_load   = 1'b1;
                    pc_write  = 1'b1;
                    alu_b_sel = B_FOUR;
                    alu_op    = ALU_ADD;
                end
            end
            S_DECODE: begin
                a_load      = 1'b1;
                b_load      = 1'b1;
                aluout_load = 1'b1;
                alu_b_sel   = B_IMM;
                imm_type    = IMM_SB;
                alu_op      = ALU_ADD;
                illegal     = dec_illegal;
            end
            S_EXEC_R: begin
                alu_a_sel = 1'b1;
                reg_write = 1'b1;
                case (iclass)
                    C_SUB:   alu_op = ALU_SUB;
                    C_AND:   alu_op = ALU_AND;
                    C_SLT:   wb_sel = WB_LT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                alu_a_sel = 1'b1;
                alu_b_sel = B_IMM;
                reg_write = 1'b1;
                if (iclass == C_SLTI) wb_sel = WB_LT;
                else                  alu_op = ALU_ADD;
            end
            S_SHIFT: begin
                wb_sel    = WB_SHIFT;
                reg_write = 1'b1;
                if (iclass == C_SRAI)      shift_sel = SH_SRA;
                else if (iclass == C_SRLI) shift_sel = SH_SRL;
            end
            S_ADDR: begin
                alu_a_sel   = 1'b1;
                alu_b_sel   = B_IMM;
                imm_type    = (iclass == C_SD) ? IMM_S : IMM_I;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_MEM_RD: begin
                dmem_read = 1'b1;
                mdr_load  = last;
            end
            S_MEM_WB: begin
                wb_sel    = WB_MDR;
                reg_write = 1'b1;
            end
            S_MEM_WR: dmem_write = 1'b1;
            S_BRANCH: begin
                alu_a_sel = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = (iclass == C_BNE) ? ~alu_zero : alu_zero;
            end
            // Link and jump share one cycle; the target uses the latched A register.
            S_JALR: begin
                wb_sel    = WB_PC;
                reg_write = 1'b1;
                alu_a_sel = 1'b1;
                alu_b_sel = B_IMM;
                alu_op    = ALU_ADD;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                imm_type  = IMM_U;
                wb_sel    = WB_IMM;
                reg_write = 1'b1;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP_SAVE: begin
                alu_b_sel = B_FOUR;
                alu_op    = ALU_SUB;
                epc_load  = 1'b1;
            end
            S_TRAP_JUMP: begin
                pc_src   = PC_TRAP;
                pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the RISC-V datapath, successor to the fixed single-latency controller. It sequences fetch, decode, execute, memory and writeback for the supported RV64I subset. Memory latency is configurable and handled by an internal wait counter. Every output is fully defined every cycle, and illegal instructions can optionally trap. It sits beside the datapath and drives all of its load enables and mux selects.

## Interface
- MEM_LAT, 1: cycles each instruction or data memory access holds its read/write strobe (≥1)
- CNT_W, $clog2(MEM_LAT+1): wait-counter width (derived, not overridden)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  32  IR contents (stable from DECODE onward)
- alu_zero  in  1  ALU zero flag from the current-cycle compare
- imem_read, dmem_read, dmem_write  out  1  memory strobes
- ir_load, a_load, b_load, aluout_load, mdr_load, reg_write, pc_write  out  1  enables
- pc_src  out  2  next-PC select: 0 ALU, 1 ALUOut, 2 trap vector
- alu_a_sel  out  1  ALU A operand: 0 PC, 1 reg A
- alu_b_sel  out  2  ALU B operand: 0 reg B, 1 constant 4, 2 immediate
- alu_op  out  3  0 pass/compare, 1 add, 2 sub, 3 and
- imm_type  out  3  immediate format: 0 I, 1 S, 2 SB, 3 U
- shift_sel  out  2  shift type: 0 sll, 1 srl, 2 sra
- wb_sel  out  3  writeback source: 0 ALU, 1 MDR, 2 imm, 3 lt, 4 shifter, 5 PC
- epc_load, illegal  out  1  trap capture enable; one-cycle illegal-instruction pulse
- state_dbg  out  4  current state encoding

## Operation
- Every output defaults to 0 each cycle. A state drives only its listed signals, so no latches are inferred.
- **RESET:** all outputs 0. Goes to FETCH on the next edge.
- **FETCH:** imem_read=1 for MEM_LAT cycles. On the last cycle: ir_load=1, pc_write=1, pc_src=0, alu_a_sel=0, alu_b_sel=1, alu_op=1 (PC←PC+4). Then goes to DECODE.
- **DECODE:** a_load=b_load=aluout_load=1, alu_a_sel=0, alu_b_sel=2, imm_type=2, alu_op=1 (ALUOut←PC+branch offset). Dispatches as follows:
  - R-type 0110011: add (f7=0, f3=000), sub (f7=0100000, f3=000), and (f7=0, f3=111), slt (f7=0, f3=010) → EXEC_R
  - I-type 0010011: addi (000), slti (010) → EXEC_I; slli (001), srli (101, f6=0), srai (101, f6=010000) → SHIFT
  - ld (0000011/011) and sd (0100011/011) → ADDR
  - beq (1100011/000) and bne (1100011/001) → BRANCH
  - jalr (1100111/000) → JALR
  - lui (0110111) → LUI
  - anything else: illegal=1, then TRAP_SAVE (or FETCH, see Configuration)
- **EXEC_R / EXEC_I:** alu_a_sel=1, alu_b_sel 0 or 2 (imm_type 0), alu_op per instruction (slt/slti: alu_op=0, wb_sel=3). reg_write=1. Then FETCH.
- **SHIFT:** shift_sel from funct3/f6, wb_sel=4, reg_write=1. Then FETCH.
- **ADDR:** alu_a_sel=1, alu_b_sel=2, imm_type 0 (ld) or 1 (sd), alu_op=1, aluout_load=1. Then MEM_RD (ld) or MEM_WR (sd).
- **MEM_RD:** dmem_read=1 for MEM_LAT cycles, mdr_load on the last cycle. Then MEM_WB.
- **MEM_WB:** wb_sel=1, reg_write=1. Then FETCH.
- **MEM_WR:** dmem_write=1 for MEM_LAT cycles. Then FETCH.
- **BRANCH:** alu_a_sel=1, alu_b_sel=0, alu_op=2, pc_src=1. pc_write = alu_zero for beq, !alu_zero for bne. Then FETCH.
- **JALR:** in a single cycle, wb_sel=5 (rd←PC, already +4) with reg_write=1, and PC←A+imm (alu_a_sel=1, alu_b_sel=2, imm_type 0, alu_op=1, pc_src=0, pc_write=1). Using the latched A makes rd==rs1 safe. Then FETCH.
- **LUI:** imm_type=3, wb_sel=2, reg_write=1. Then FETCH.
- **TRAP_SAVE:** alu_a_sel=0, alu_b_sel=1, alu_op=2, epc_load=1 (EPC←PC−4). Then TRAP_JUMP.
- **TRAP_JUMP:** pc_src=2, pc_write=1. Then FETCH.

## Timing
- Cycles per instruction, with L=MEM_LAT:
  - R/I/shift/lui/branch/jalr: L+2
  - ld: 2L+3
  - sd: 2L+2
  - trap: L+3
- The wait counter loads 0 on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle. The last cycle is when count==L−1. With L=1 there is no extra cycle.
- A reset edge at any point forces RESET and counter=0 asynchronously, and all outputs go 0 immediately. Memory strobes drop mid-access. No partial writeback or PC update occurs.
- alu_zero is sampled combinationally only in BRANCH. Its value in other states is ignored.
- instr is sampled only in DECODE and in execute states. A change during FETCH before ir_load has no effect.

## Configuration
- CTRL_TRAP_EN defined: illegal instructions take TRAP_SAVE → TRAP_JUMP.
- CTRL_TRAP_EN undefined: an illegal instruction behaves as a NOP and goes DECODE → FETCH. epc_load is tied 0 and the trap states are removed. The illegal pulse remains.

## Structure
- Package ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode/funct3/funct7 localparams
  - alu_op, wb_sel, pc_src, imm_type, alu_b_sel encodings
- Sub-module ctrl_decode: a combinational classifier that maps instr to an instruction-class enum plus an illegal flag. The FSM consumes the class.

## Test plan
- MEM_LAT=1, `add x3,x1,x2` → imem_read 1 cycle, DECODE, EXEC_R with reg_write=1, wb_sel=0; total 3 cycles.
- MEM_LAT=3, `ld` → imem_read high 3 cycles, dmem_read high 3 cycles, mdr_load on the 3rd, reg_write in MEM_WB; total 9 cycles.
- `beq` with alu_zero=1 → pc_write=1, pc_src=1. `bne` with alu_zero=1 → pc_write=0.
- `jalr x1,0(x1)` → reg_write, wb_sel=5, pc_write, pc_src=0 all in the same cycle.
- instr=0xFFFFFFFF with CTRL_TRAP_EN → illegal pulse, epc_load, then pc_src=2 with pc_write. Without the macro → FETCH directly.
- reset asserted during the 2nd MEM_RD cycle (MEM_LAT=3) → dmem_read=0 immediately, state_dbg=RESET, FETCH on the next cycle after release.
